// File: rtl/pc_alu_unit.sv
// pc_alu_unit: two-operand ALU with a zero flag, plus a program counter that
// can increment, take a zero-conditioned relative branch, or load a return
// address.
//
// Ports:
//   clk       in   single clock; all state changes on its rising edge
//   reset     in   synchronous, active-high; clears pc to 0
//   alu_op    in   2-bit operation: 00 add, 01 sub, 10 and, 11 or
//   alu_a     in   operand A
//   alu_b     in   operand B
//   alu_y     out  ALU result (combinational, modulo 2^WIDTH)
//   zero      out  alu_y == 0 (combinational)
//   br_cond   in   branch request; taken only while zero is high
//   jmp       in   unconditional load of ret_addr (beats br_cond)
//   ret_addr  in   return address
//   j_offset  in   two's-complement branch offset
//   pc_jump   out  pc + j_offset (combinational)
//   pc        out  registered program counter
//   alu_carry out  only with PC_ALU_CARRY_EN defined: carry-out of add,
//                  borrow of sub, 0 for and/or
//
// Build option: define PC_ALU_CARRY_EN to add the alu_carry output.
module pc_alu_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_y,
  output logic             zero,
  input  logic             br_cond,
  input  logic             jmp,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic [WIDTH-1:0] j_offset,
  output logic [WIDTH-1:0] pc_jump,
  output logic [WIDTH-1:0] pc
`ifdef PC_ALU_CARRY_EN
  ,
  output logic             alu_carry
`endif
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  alu_op_e          op;
  logic             load;
  logic [WIDTH-1:0] load_val;

  assign op = alu_op_e'(alu_op);

`ifdef PC_ALU_CARRY_EN
  // One extra bit on the add/sub holds the carry-out, or the borrow for sub.
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;

  assign add_ext = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_ext = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    alu_y     = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y     = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
      end
      OP_SUB: begin
        alu_y     = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
      end
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      default: alu_y = '0;
    endcase
  end
`else
  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = alu_a + alu_b;
      OP_SUB:  alu_y = alu_a - alu_b;
      OP_AND:  alu_y = alu_a & alu_b;
      OP_OR:   alu_y = alu_a | alu_b;
      default: alu_y = '0;
    endcase
  end
`endif

  assign zero = (alu_y == '0);

  // Two's-complement offset and unsigned add produce identical bits mod 2^WIDTH.
  assign pc_jump = pc + j_offset;

  assign load     = (br_cond & zero) | jmp;
  assign load_val = jmp ? ret_addr : pc_jump;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_alu_unit.sv
// Directed-vector bench for pc_alu_unit with hand-computed expectations.
module tb_pc_alu_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_y;
  logic       zero;
  logic       br_cond, jmp;
  logic [7:0] ret_addr, j_offset, pc_jump, pc;
`ifdef PC_ALU_CARRY_EN
  logic       alu_carry;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pc_alu_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_y    (alu_y),
    .zero     (zero),
    .br_cond  (br_cond),
    .jmp      (jmp),
    .ret_addr (ret_addr),
    .j_offset (j_offset),
    .pc_jump  (pc_jump),
    .pc       (pc)
`ifdef PC_ALU_CARRY_EN
    ,
    .alu_carry(alu_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    br_cond  = 1'b0;
    jmp      = 1'b0;
    ret_addr = 8'h00;
    j_offset = 8'h33;
    set_alu(2'b00, 8'h00, 8'h00);

    // Reset, then free-running increment 0,1,2,3.
    step();
    check("reset_pc", pc, 8'h00);
    check("reset_pc_jump", pc_jump, 8'h33);
    reset = 1'b0;
    step(); check("inc_1", pc, 8'h01);
    step(); check("inc_2", pc, 8'h02);
    step(); check("inc_3", pc, 8'h03);

    // ALU vectors.
    set_alu(2'b00, 8'hF0, 8'h10);
    check("add_y", alu_y, 8'h00);
    check("add_zero", zero, 1'b1);
`ifdef PC_ALU_CARRY_EN
    check("add_carry", alu_carry, 1'b1);
`endif
    set_alu(2'b01, 8'h05, 8'h07);
    check("sub_y", alu_y, 8'hFE);
    check("sub_zero", zero, 1'b0);
`ifdef PC_ALU_CARRY_EN
    check("sub_borrow", alu_carry, 1'b1);
`endif
    set_alu(2'b10, 8'hCC, 8'h0F);
    check("and_y", alu_y, 8'h0C);
`ifdef PC_ALU_CARRY_EN
    check("and_carry", alu_carry, 1'b0);
`endif
    set_alu(2'b11, 8'hC0, 8'h03);
    check("or_y", alu_y, 8'hC3);
    check("or_zero", zero, 1'b0);

    // Reach pc=4 with br_cond low, ALU still nonzero.
    step(); check("inc_4", pc, 8'h04);

    // Taken branch: zero forced high, offset -2.
    j_offset = 8'hFE;
    br_cond  = 1'b1;
    set_alu(2'b00, 8'h00, 8'h00);
    check("br_zero", zero, 1'b1);
    check("br_pc_jump", pc_jump, 8'h02);
    step(); check("br_taken", pc, 8'h02);

    // Back to pc=4 without branching, then branch request with zero low.
    br_cond = 1'b0;
    step(); check("inc_after_br", pc, 8'h03);
    step(); check("inc_to_4", pc, 8'h04);
    br_cond = 1'b1;
    set_alu(2'b00, 8'h01, 8'h00);
    check("nobr_zero", zero, 1'b0);
    step(); check("br_not_taken", pc, 8'h05);

    // Return: jmp beats a simultaneously valid branch.
    set_alu(2'b00, 8'h00, 8'h00);
    jmp      = 1'b1;
    ret_addr = 8'h40;
    step(); check("ret_priority", pc, 8'h40);

    // Wrap: load 0xFE, then increment through 0xFF to 0x00.
    br_cond  = 1'b0;
    ret_addr = 8'hFE;
    step(); check("ret_fe", pc, 8'hFE);
    jmp = 1'b0;
    step(); check("wrap_ff", pc, 8'hFF);
    step(); check("wrap_00", pc, 8'h00);

    // Reset wins over a pending load.
    step(); check("pre_rst", pc, 8'h01);
    reset    = 1'b1;
    jmp      = 1'b1;
    ret_addr = 8'h55;
    step(); check("reset_over_load", pc, 8'h00);
    reset = 1'b0;
    jmp   = 1'b0;
    step(); check("first_inc_after_rst", pc, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
